// File: rtl/counter_sequencer.sv
// counter_sequencer: run-control FSM around an N-bit up-counter.
// The count runs 0..lim over a number of passes, with start/stop/pause control.
// The terminal tick is decoded combinationally from state and count.
// busy and done come from registers loaded with the next-state decode.
module counter_sequencer #(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic [N-1:0] limit,
  input  logic [R-1:0] passes,
  output logic [N-1:0] count,
  output logic [R-1:0] pass_num,
  output logic         busy,
  output logic         tick,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_r, state_s;
  logic [N-1:0] count_r, count_s;
  logic [R-1:0] pass_r,  pass_s;
  logic [N-1:0] lim_r,   lim_s;
  logic [R-1:0] pas_r,   pas_s;
  logic [R-1:0] pass_inc_s;
  logic         busy_r,  done_r;

  // Next-state and datapath update; stop outranks pause, pause outranks the wrap.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    pass_s     = pass_r;
    lim_s      = lim_r;
    pas_s      = pas_r;
    pass_inc_s = pass_r + R'(1);
    case (state_r)
      IDLE: begin
        count_s = '0;
        if (start) begin
          lim_s   = limit;
          pas_s   = passes;
          pass_s  = '0;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          count_s = '0;
          state_s = IDLE;
        end else if (pause) begin
          state_s = HOLD;
        end else if (count_r == lim_r) begin
          count_s = '0;
          pass_s  = pass_inc_s;
          // A zero pass budget means run until stopped.
          if ((pas_r != '0) && (pass_inc_s == pas_r)) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          count_s = count_r + N'(1);
        end
      end
      HOLD: begin
        if (stop) begin
          count_s = '0;
          state_s = IDLE;
        end else if (!pause) begin
          state_s = RUN;
        end else begin
          state_s = HOLD;
        end
      end
      DONE: begin
        count_s = '0;
        state_s = IDLE;
      end
      default: begin
        count_s = '0;
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and status registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= '0;
      pass_r  <= '0;
      lim_r   <= '0;
      pas_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      pass_r  <= pass_s;
      lim_r   <= lim_s;
      pas_r   <= pas_s;
      busy_r  <= (state_s == RUN) || (state_s == HOLD);
      done_r  <= (state_s == DONE);
    end
  end

  assign count    = count_r;
  assign pass_num = pass_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign tick     = (state_r == RUN) && (count_r == lim_r);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed testbench for counter_sequencer with hand-computed expectations.
// The observed vector is {count, pass_num, busy, tick, done}.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, pause;
  logic [3:0] limit, passes;
  logic [3:0] count, pass_num;
  logic       busy, tick, done;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [10:0] exp_v;
  wire  [10:0] obs = {count, pass_num, busy, tick, done};

  counter_sequencer #(.N(4), .R(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .limit(limit), .passes(passes), .count(count), .pass_num(pass_num),
    .busy(busy), .tick(tick), .done(done)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    limit = 4'd0; passes = 4'd0;
    step(); step();
    exp_v = 11'd0;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset obs=%h exp=%h", obs, exp_v); end
    reset = 1'b0;
    step();
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL idle_after_reset obs=%h exp=%h", obs, exp_v); end
  endtask

  // limit=3, passes=2: two passes of 0..3, done pulse, then idle.
  task automatic test_basic();
    limit = 4'd3; passes = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_v = {4'(k % 4), 4'(k / 4), 1'b1, 1'((k % 4) == 3), 1'b0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL basic k=%0d obs=%h exp=%h", k, obs, exp_v); end
      step();
    end
    exp_v = {4'd0, 4'd2, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL basic_done obs=%h exp=%h", obs, exp_v); end
    step();
    exp_v = {4'd0, 4'd2, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL basic_idle obs=%h exp=%h", obs, exp_v); end
  endtask

  // limit=0, passes=3: tick on three consecutive cycles, then done.
  task automatic test_limit_zero();
    limit = 4'd0; passes = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_v = {4'd0, 4'(k), 1'b1, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL lim0 k=%0d obs=%h exp=%h", k, obs, exp_v); end
      step();
    end
    exp_v = {4'd0, 4'd3, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL lim0_done obs=%h exp=%h", obs, exp_v); end
    step();
  endtask

  // limit=15, passes=0: full-range wrap, no done, stop returns to idle;
  // then limit=0, passes=0 to see pass_num wrap modulo 16.
  task automatic test_free_run();
    limit = 4'd15; passes = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      exp_v = {4'(k % 16), 4'(k / 16), 1'b1, 1'((k % 16) == 15), 1'b0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL free k=%0d obs=%h exp=%h", k, obs, exp_v); end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    exp_v = {4'd0, 4'd2, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL free_stop obs=%h exp=%h", obs, exp_v); end
    limit = 4'd0; passes = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 18; k++) step();
    exp_v = {4'd0, 4'd2, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pass_wrap obs=%h exp=%h", obs, exp_v); end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Pause mid-count and pause on the terminal count.
  task automatic test_pause();
    limit = 4'd3; passes = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    exp_v = {4'd2, 4'd0, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pause_pre obs=%h exp=%h", obs, exp_v); end
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL pause_hold k=%0d obs=%h exp=%h", k, obs, exp_v); end
    end
    pause = 1'b0;
    step();
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pause_release obs=%h exp=%h", obs, exp_v); end
    step();
    exp_v = {4'd3, 4'd0, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pause_resume obs=%h exp=%h", obs, exp_v); end
    step();
    exp_v = {4'd0, 4'd1, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pause_done obs=%h exp=%h", obs, exp_v); end
    step();
    // pause on terminal count: wrap deferred until after release
    limit = 4'd1; passes = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    pause = 1'b1;
    step(); step();
    exp_v = {4'd1, 4'd0, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL term_pause obs=%h exp=%h", obs, exp_v); end
    pause = 1'b0;
    step();
    exp_v = {4'd1, 4'd0, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL term_release obs=%h exp=%h", obs, exp_v); end
    step();
    exp_v = {4'd0, 4'd1, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL term_done obs=%h exp=%h", obs, exp_v); end
    step();
  endtask

  // stop+pause together, stop from HOLD, start ignored mid-run, limit latched.
  task automatic test_stop_and_ignore();
    limit = 4'd3; passes = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    stop = 1'b1; pause = 1'b1;
    step();
    stop = 1'b0; pause = 1'b0;
    exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL stop_pause obs=%h exp=%h", obs, exp_v); end
    start = 1'b1;
    step();
    start = 1'b0; pause = 1'b1;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0; pause = 1'b0;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL stop_hold obs=%h exp=%h", obs, exp_v); end
    limit = 4'd2; passes = 4'd1; start = 1'b1;
    step();
    limit = 4'd7; passes = 4'd5;
    step(); step();
    exp_v = {4'd2, 4'd0, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL latch_limit obs=%h exp=%h", obs, exp_v); end
    step();
    exp_v = {4'd0, 4'd1, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL start_ign_done obs=%h exp=%h", obs, exp_v); end
    step();
    exp_v = {4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL done_to_idle obs=%h exp=%h", obs, exp_v); end
    start = 1'b0;
  endtask

  // Reset mid-run, then a normal run afterwards.
  task automatic test_reset_mid_run();
    limit = 4'd3; passes = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    exp_v = {4'd2, 4'd1, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_run obs=%h exp=%h", obs, exp_v); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_v = 11'd0;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_reset obs=%h exp=%h", obs, exp_v); end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limit_zero();
    test_free_run();
    test_pause();
    test_stop_and_ignore();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
